// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared state encoding, default line size and width helper
//                for the cache-to-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Transaction FSM encoding
    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_wdata = 2'd1;
    localparam logic [1:0] c_rdata = 2'd2;

    // Data beats per cache line
    localparam int c_beats_default = 4;

    // ceilLog2 that never returns zero, so 1-entry cases still get a 1-bit reg
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Requester-side and memory-side bus of the memory arbiter.
//                slave  = arbiter view, master = requesters + memory view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int NREQ      = 2,
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128
);
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ*ADDR_BITS-1:0]   req_addr;
    logic [NREQ-1:0]             req_rw;
    logic [NREQ-1:0]             req_data_valid;
    logic [NREQ-1:0]             req_data_ready;
    logic [NREQ*DATA_BITS-1:0]   req_data_bits;
    logic [NREQ*DATA_BITS/8-1:0] req_data_mask;
    logic [NREQ-1:0]             resp_valid;
    logic [DATA_BITS-1:0]        resp_data;

    logic                        mem_req_valid;
    logic                        mem_req_ready;
    logic [ADDR_BITS-1:0]        mem_req_addr;
    logic                        mem_req_rw;
    logic                        mem_req_data_valid;
    logic                        mem_req_data_ready;
    logic [DATA_BITS-1:0]        mem_req_data_bits;
    logic [DATA_BITS/8-1:0]      mem_req_data_mask;
    logic                        mem_resp_valid;
    logic [DATA_BITS-1:0]        mem_resp_data;

    modport slave (
        input  req_valid, req_addr, req_rw, req_data_valid, req_data_bits,
               req_data_mask, mem_req_ready, mem_req_data_ready,
               mem_resp_valid, mem_resp_data,
        output req_ready, req_data_ready, resp_valid, resp_data,
               mem_req_valid, mem_req_addr, mem_req_rw, mem_req_data_valid,
               mem_req_data_bits, mem_req_data_mask
    );

    modport master (
        output req_valid, req_addr, req_rw, req_data_valid, req_data_bits,
               req_data_mask, mem_req_ready, mem_req_data_ready,
               mem_resp_valid, mem_resp_data,
        input  req_ready, req_data_ready, resp_valid, resp_data,
               mem_req_valid, mem_req_addr, mem_req_rw, mem_req_data_valid,
               mem_req_data_bits, mem_req_data_mask
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Rotating-priority one-hot picker. The requester at index
//                'pointer' has highest priority, then pointer+1, wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [PTR_W-1:0] pointer,
    output logic [NREQ-1:0]  grant
);

    logic w_found;

    // Scan priority slots in order; the first valid requester takes the grant
    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!w_found && valid[i] && (i == (int'(pointer) + k) % NREQ)) begin
                    grant[i] = 1'b1;
                    w_found  = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Arbitrates NREQ cache requesters onto one line-based memory
//                port, one transaction (address + BEATS data beats) at a time.
//                Optional macro MEM_ARB_ROUND_ROBIN_EN enables rotating
//                priority; otherwise the lowest index always wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128,
    parameter int BEATS     = c_beats_default
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int                 c_ptr_w     = clog2_min1(NREQ);
    localparam int                 c_cnt_w     = clog2_min1(BEATS);
    localparam int                 c_mask_bits = DATA_BITS / 8;
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(BEATS - 1);

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_ptr_w-1:0] r_owner;
    logic [c_ptr_w-1:0] w_pointer;
    logic [NREQ-1:0]    w_grant;
    logic [c_ptr_w-1:0] w_winner;
    logic               w_addr_hs;
    logic               w_data_hs;
    logic               w_resp_beat;
    logic               w_last;

    rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (c_ptr_w)
    ) u_picker (
        .valid   (bus.req_valid),
        .pointer (w_pointer),
        .grant   (w_grant)
    );

    // Encode the one-hot grant as the winning requester index
    always_comb begin
        w_winner = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_winner = c_ptr_w'(i);
            end
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam logic [c_ptr_w-1:0] c_last_req = c_ptr_w'(NREQ - 1);
    logic [c_ptr_w-1:0] r_pointer;

    // After a grant to i, requester i+1 (wrapping) gets top priority
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pointer <= '0;
        end else if (w_addr_hs) begin
            r_pointer <= (w_winner == c_last_req) ? '0 : w_winner + 1'b1;
        end
    end
    assign w_pointer = r_pointer;
`else
    assign w_pointer = '0;
`endif

    assign w_addr_hs   = (r_state == c_idle)  && bus.mem_req_valid && bus.mem_req_ready;
    assign w_data_hs   = (r_state == c_wdata) && bus.mem_req_data_valid && bus.mem_req_data_ready;
    assign w_resp_beat = (r_state == c_rdata) && bus.mem_resp_valid && !reset;
    assign w_last      = (r_cnt == c_last_beat);

    // Transaction FSM: capture owner on address handshake, count data beats
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
            r_cnt   <= '0;
            r_owner <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_addr_hs) begin
                        r_owner <= w_winner;
                        r_cnt   <= '0;
                        r_state <= bus.mem_req_rw ? c_wdata : c_rdata;
                    end
                end
                c_wdata: begin
                    if (w_data_hs) begin
                        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                        if (w_last) begin
                            r_state <= c_idle;
                        end
                    end
                end
                c_rdata: begin
                    if (w_resp_beat) begin
                        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                        if (w_last) begin
                            r_state <= c_idle;
                        end
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    // Steer handshakes between the winner/owner and memory; all quiet in reset
    always_comb begin
        bus.req_ready          = '0;
        bus.req_data_ready     = '0;
        bus.resp_valid         = '0;
        bus.mem_req_valid      = 1'b0;
        bus.mem_req_data_valid = 1'b0;
        bus.mem_req_addr       = bus.req_addr[int'(w_winner)*ADDR_BITS +: ADDR_BITS];
        bus.mem_req_rw         = bus.req_rw[w_winner];
        bus.mem_req_data_bits  = bus.req_data_bits[int'(r_owner)*DATA_BITS +: DATA_BITS];
        bus.mem_req_data_mask  = bus.req_data_mask[int'(r_owner)*c_mask_bits +: c_mask_bits];
        bus.resp_data          = bus.mem_resp_data;
        if (!reset) begin
            case (r_state)
                c_idle: begin
                    bus.mem_req_valid       = |bus.req_valid;
                    bus.req_ready[w_winner] = bus.mem_req_ready && (|bus.req_valid);
                end
                c_wdata: begin
                    bus.mem_req_data_valid      = bus.req_data_valid[r_owner];
                    bus.req_data_ready[r_owner] = bus.mem_req_data_ready;
                end
                c_rdata: begin
                    bus.resp_valid[r_owner] = bus.mem_resp_valid;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed vector table plus hand-written sequences for the
//                memory arbiter (read, write, arbitration, stall, reset).
//                Expectations follow MEM_ARB_ROUND_ROBIN_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam logic [27:0]  DC_ADDR = 28'h10;
    localparam logic [27:0]  IC_ADDR = 28'h20;
    localparam logic [127:0] DC_DATA = 128'hD0D0_D0D0_0000_1111_2222_3333_4444_5555;
    localparam logic [127:0] IC_DATA = 128'h1C1C_1C1C_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
    localparam logic [15:0]  DC_MASK = 16'h00FF;
    localparam logic [15:0]  IC_MASK = 16'hF0F0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_arbiter_if #(.NREQ(2), .ADDR_BITS(28), .DATA_BITS(128)) bus ();

    mem_arbiter #(.NREQ(2), .ADDR_BITS(28), .DATA_BITS(128), .BEATS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] rv, rw, dv;
        logic       mrr, mdr, mrv;
        logic [1:0] e_rr;
        logic       e_mv;
        logic [27:0] e_addr;
        logic       e_rw;
        logic [1:0] e_dr;
        logic       e_mdv;
        logic [15:0] e_mask;
        logic [1:0] e_resp;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t v(input logic rst, input logic [1:0] rv, rw, dv,
                               input logic mrr, mdr, mrv,
                               input logic [1:0] e_rr, input logic e_mv,
                               input logic [27:0] e_addr, input logic e_rw,
                               input logic [1:0] e_dr, input logic e_mdv,
                               input logic [15:0] e_mask, input logic [1:0] e_resp);
        vec_t r;
        r.rst = rst; r.rv = rv; r.rw = rw; r.dv = dv;
        r.mrr = mrr; r.mdr = mdr; r.mrv = mrv;
        r.e_rr = e_rr; r.e_mv = e_mv; r.e_addr = e_addr; r.e_rw = e_rw;
        r.e_dr = e_dr; r.e_mdv = e_mdv; r.e_mask = e_mask; r.e_resp = e_resp;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] rv, rw, dv, input logic mrr, mdr, mrv);
        bus.req_valid          = rv;
        bus.req_rw             = rw;
        bus.req_data_valid     = dv;
        bus.mem_req_ready      = mrr;
        bus.mem_req_data_ready = mdr;
        bus.mem_resp_valid     = mrv;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int           ngr;
        int           exp_g;
        int           last_g;
        logic [127:0] rdata;

        bus.req_addr      = {IC_ADDR, DC_ADDR};
        bus.req_data_bits = {IC_DATA, DC_DATA};
        bus.req_data_mask = {IC_MASK, DC_MASK};
        bus.mem_resp_data = '0;
        drive(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        //                rst rv     rw     dv     mrr mdr mrv  rr     mv  addr     rw  dr     mdv mask     resp
        vecs[0]  = v(1, 2'b11, 2'b00, 2'b11, 1, 1, 1, 2'b00, 0, DC_ADDR, 0, 2'b00, 0, DC_MASK, 2'b00);
        vecs[1]  = v(0, 2'b00, 2'b00, 2'b00, 1, 1, 1, 2'b00, 0, DC_ADDR, 0, 2'b00, 0, DC_MASK, 2'b00);
        vecs[2]  = v(0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b00, 1, DC_ADDR, 0, 2'b00, 0, DC_MASK, 2'b00);
        vecs[3]  = v(0, 2'b01, 2'b00, 2'b00, 1, 0, 0, 2'b01, 1, DC_ADDR, 0, 2'b00, 0, DC_MASK, 2'b00);
        vecs[4]  = v(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, DC_ADDR, 0, 2'b00, 0, DC_MASK, 2'b00);
        vecs[5]  = v(0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b00, 0, DC_ADDR, 0, 2'b00, 0, DC_MASK, 2'b01);
        vecs[6]  = v(0, 2'b10, 2'b10, 2'b00, 1, 0, 1, 2'b00, 0, DC_ADDR, 0, 2'b00, 0, DC_MASK, 2'b01);
        vecs[7]  = v(0, 2'b10, 2'b10, 2'b00, 1, 0, 1, 2'b00, 0, DC_ADDR, 0, 2'b00, 0, DC_MASK, 2'b01);
        vecs[8]  = v(0, 2'b10, 2'b10, 2'b00, 1, 0, 1, 2'b00, 0, DC_ADDR, 0, 2'b00, 0, DC_MASK, 2'b01);
        vecs[9]  = v(0, 2'b10, 2'b10, 2'b00, 1, 0, 1, 2'b10, 1, IC_ADDR, 1, 2'b00, 0, IC_MASK, 2'b00);
        vecs[10] = v(0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 2'b00, 0, IC_ADDR, 0, 2'b00, 1, IC_MASK, 2'b00);
        vecs[11] = v(0, 2'b00, 2'b00, 2'b11, 0, 1, 0, 2'b00, 0, IC_ADDR, 0, 2'b10, 1, IC_MASK, 2'b00);
        vecs[12] = v(0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 2'b00, 0, IC_ADDR, 0, 2'b00, 1, IC_MASK, 2'b00);
        vecs[13] = v(0, 2'b00, 2'b00, 2'b11, 0, 1, 0, 2'b00, 0, IC_ADDR, 0, 2'b10, 1, IC_MASK, 2'b00);
        vecs[14] = v(0, 2'b00, 2'b00, 2'b01, 0, 1, 0, 2'b00, 0, IC_ADDR, 0, 2'b10, 0, IC_MASK, 2'b00);
        vecs[15] = v(0, 2'b00, 2'b00, 2'b10, 0, 1, 0, 2'b00, 0, IC_ADDR, 0, 2'b10, 1, IC_MASK, 2'b00);
        vecs[16] = v(0, 2'b00, 2'b00, 2'b10, 0, 1, 1, 2'b00, 0, IC_ADDR, 0, 2'b10, 1, IC_MASK, 2'b00);
        vecs[17] = v(0, 2'b00, 2'b00, 2'b10, 0, 1, 0, 2'b00, 0, IC_ADDR, 0, 2'b00, 0, IC_MASK, 2'b00);

        // Vector table: reset, stray response, dcache read, icache write
        for (int i = 0; i < 18; i++) begin
            reset = vecs[i].rst;
            drive(vecs[i].rv, vecs[i].rw, vecs[i].dv, vecs[i].mrr, vecs[i].mdr, vecs[i].mrv);
            @(negedge clk);
            chk($sformatf("v%0d req_ready", i), bus.req_ready, vecs[i].e_rr);
            chk($sformatf("v%0d mem_req_valid", i), bus.mem_req_valid, vecs[i].e_mv);
            if (vecs[i].e_mv) begin
                chk($sformatf("v%0d mem_req_addr", i), bus.mem_req_addr, vecs[i].e_addr);
                chk($sformatf("v%0d mem_req_rw", i), bus.mem_req_rw, vecs[i].e_rw);
            end
            chk($sformatf("v%0d req_data_ready", i), bus.req_data_ready, vecs[i].e_dr);
            chk($sformatf("v%0d mem_req_data_valid", i), bus.mem_req_data_valid, vecs[i].e_mdv);
            if (vecs[i].e_mdv) begin
                chk($sformatf("v%0d mem_req_data_mask", i), bus.mem_req_data_mask, vecs[i].e_mask);
                chk($sformatf("v%0d mem_req_data_bits", i), bus.mem_req_data_bits,
                    (vecs[i].e_mask == IC_MASK) ? IC_DATA : DC_DATA);
            end
            chk($sformatf("v%0d resp_valid", i), bus.resp_valid, vecs[i].e_resp);
            next_cycle();
        end

        // Both requesters valid every cycle: alternating or fixed grants
        ngr    = 0;
        last_g = 0;
        drive(2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 40 && ngr < 4; c++) begin
            rdata = {4{32'(c + 100)}};
            bus.mem_resp_data = rdata;
            @(negedge clk);
            if (bus.req_ready != 2'b00) begin
                exp_g = RR ? (ngr % 2) : 0;
                chk($sformatf("arb grant %0d", ngr), bus.req_ready, 2'b01 << exp_g);
                chk($sformatf("arb addr %0d", ngr), bus.mem_req_addr, exp_g ? IC_ADDR : DC_ADDR);
                last_g = exp_g;
                ngr++;
            end else begin
                chk("arb resp_valid", bus.resp_valid, 2'b01 << last_g);
                chk("arb resp_data", bus.resp_data, rdata);
            end
            next_cycle();
        end
        if (ngr < 4) begin
            n_checks++;
            n_fail++;
            $display("FAIL arb timeout: got %0d grants expected 4", ngr);
        end
        drive(2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("arb drain resp_valid", bus.resp_valid, 2'b01 << last_g);
            next_cycle();
        end

        // Memory stalls the address for 5 cycles; request must hold steady
        drive(2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall req_ready", bus.req_ready, 2'b00);
            chk("stall mem_req_valid", bus.mem_req_valid, 1'b1);
            chk("stall addr", bus.mem_req_addr, IC_ADDR);
            next_cycle();
        end
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        chk("stall release req_ready", bus.req_ready, 2'b10);
        next_cycle();
        drive(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("ic read resp_valid", bus.resp_valid, 2'b10);
            next_cycle();
        end
        @(negedge clk);
        chk("ic read done stray resp", bus.resp_valid, 2'b00);
        next_cycle();

        // Reset after 2 of 4 read beats aborts; next read completes normally
        drive(2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst seq grant", bus.req_ready, 2'b01);
        next_cycle();
        drive(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst seq beat", bus.resp_valid, 2'b01);
            next_cycle();
        end
        reset = 1'b1;
        drive(2'b11, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("in reset req_ready", bus.req_ready, 2'b00);
            chk("in reset req_data_ready", bus.req_data_ready, 2'b00);
            chk("in reset resp_valid", bus.resp_valid, 2'b00);
            chk("in reset mem_req_valid", bus.mem_req_valid, 1'b0);
            chk("in reset mem_req_data_valid", bus.mem_req_data_valid, 1'b0);
            next_cycle();
        end
        reset = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("post reset no beat", bus.resp_valid, 2'b00);
        next_cycle();
        drive(2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("post reset grant", bus.req_ready, 2'b01);
        next_cycle();
        drive(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post reset beat", bus.resp_valid, 2'b01);
            next_cycle();
        end
        drive(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("post reset back idle", bus.mem_req_valid, 1'b1);
        chk("post reset idle resp", bus.resp_valid, 2'b00);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NREQ, default 2, number of cache requesters; index 0 is the dcache, index 1 is the icache.
REQ-002 Parameter ADDR_BITS, default 28, width of the line-granular memory address.
REQ-003 Parameter DATA_BITS, default 128, width of `MEM_DATA_BITS; BEATS, default 4, data beats per line.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  NREQ  per-requester address request valid.
REQ-007 req_ready  out  NREQ  per-requester address accepted.
REQ-008 req_addr  in  NREQ*ADDR_BITS  packed line addresses; slice i belongs to requester i.
REQ-009 req_rw  in  NREQ  1=write, 0=read.
REQ-010 req_data_valid  in  NREQ  write data beat valid.
REQ-011 req_data_ready  out  NREQ  write data beat accepted.
REQ-012 req_data_bits  in  NREQ*DATA_BITS  packed write data.
REQ-013 req_data_mask  in  NREQ*DATA_BITS/8  packed byte masks.
REQ-014 resp_valid  out  NREQ  read beat for requester i.
REQ-015 resp_data  out  DATA_BITS  read beat data, broadcast to all requesters.
REQ-016 mem_req_valid/mem_req_ready  out/in  1/1  memory address handshake.
REQ-017 mem_req_addr, mem_req_rw  out  ADDR_BITS, 1  granted address and direction.
REQ-018 mem_req_data_valid/mem_req_data_ready  out/in  1/1  memory write data handshake.
REQ-019 mem_req_data_bits, mem_req_data_mask  out  DATA_BITS, DATA_BITS/8  granted write beat.
REQ-020 mem_resp_valid, mem_resp_data  in  1, DATA_BITS  memory read beats.

Function
REQ-021 FSM states IDLE, WDATA, RDATA; exactly one transaction in flight.
REQ-022 IDLE: winner is chosen combinationally from req_valid; mem_req_valid=|req_valid; addr/rw muxed from the winner.
REQ-023 req_ready[i]=mem_req_ready when state is IDLE and i is the winner, else 0; zero-cycle pass-through.
REQ-024 An address handshake (mem_req_valid&&mem_req_ready) latches owner=winner and clears beat counter; rw=1 moves to WDATA, rw=0 to RDATA.
REQ-025 WDATA: mem_req_data_valid/bits/mask come from the owner only; req_data_ready[owner]=mem_req_data_ready; all other data_ready are 0.
REQ-026 WDATA: each data handshake increments the counter; the handshake at count BEATS-1 returns to IDLE in the next cycle.
REQ-027 RDATA: resp_valid[owner]=mem_resp_valid; all others 0; the beat at count BEATS-1 returns to IDLE.
REQ-028 mem_resp_valid in IDLE or WDATA is dropped and never forwarded; mem_req_data_valid=0 outside WDATA.
REQ-029 A new address is accepted no earlier than the cycle after the final beat (no overlap).
REQ-030 Counter width is ceilLog2(BEATS) and it wraps to 0 on the final beat.

Reset
REQ-031 While reset is high: state=IDLE, counter=0, owner=0, and the round-robin pointer=0.
REQ-032 While reset is high, all ready and valid outputs are 0.
REQ-033 Reset mid-transaction aborts the transaction with no further beats forwarded.

Configuration
REQ-034 With MEM_ARB_ROUND_ROBIN_EN defined, priority rotates: after a grant to i, requester (i+1)%NREQ has highest priority.
REQ-035 With MEM_ARB_ROUND_ROBIN_EN undefined, priority is fixed: the lowest index wins, and no pointer register is built.

Structure
REQ-036 Package mem_arb_pkg holds the state encoding and the BEATS default.
REQ-037 Winner selection is the sub-module rr_picker, with inputs valid and pointer and a one-hot grant output.

Verification
REQ-038 Single read: dc read addr 0x10, 4 resp beats D0..D3 -> resp_valid[0] asserted 4 cycles, resp_valid[1]=0, state returns to IDLE.
REQ-039 Write: ic write addr 0x20, mem_req_data_ready toggling -> exactly 4 beats pass with ic's mask, then IDLE.
REQ-040 Both requesters valid every cycle, RR_EN defined -> grants alternate 0,1,0,1; RR_EN undefined -> grants are all 0.
REQ-041 mem_req_ready=0 for 5 cycles -> req_ready=0, grant holds, addr stable.
REQ-042 Reset asserted after 2 of 4 read beats -> all outputs 0; next dc read completes normally.
REQ-043 Stray mem_resp_valid in IDLE -> no resp_valid asserted.
